keccak_squeeze_serializer: RTL and testbench

//   Reader side of the 1600-bit Keccak state bus. Captures a finished permutation

---
 rtl/keccak_squeeze_serializer.sv | 107 ++++++++++
 tb/tb_keccak_squeeze_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_serializer.sv
// Captures a finished Keccak state and streams its first DIGEST_WORDS lanes as 64-bit words.
// Latency: state accepted at edge N, first word valid right after edge N; 1 word/cycle steady.
// Backpressure: out_ready=0 freezes the word and count; state_ready rises combinationally only when idle or on the last handshake.
module keccak_squeeze_serializer #(
    parameter int DIGEST_WORDS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    output logic [63:0]   out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    localparam logic [4:0] LAST_IDX = 5'(DIGEST_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_t;

    fsm_t                          fsm_q;
    fsm_t                          fsm_d;
    logic [4:0]                    cnt_q;
    logic [DIGEST_WORDS-1:0][63:0] lanes_q;
    logic                          at_last;
    logic                          capture;
    logic                          advance;
    logic [63:0]                   cur_word;

    // Lanes beyond the digest length are never stored; fold them here so the
    // whole input bus is visibly consumed.
    logic unused_state_bits;
    assign unused_state_bits = ^state_in;

    assign at_last = (cnt_q == LAST_IDX);
    assign capture = state_valid && state_ready;
    assign advance = (fsm_q == SEND) && out_ready && !at_last;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state: a new state can be taken on the very cycle the last word leaves
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: if (state_valid) fsm_d = SEND;
            SEND: if (out_ready && at_last) fsm_d = state_valid ? SEND : IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Lane buffer and word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q <= '0;
            cnt_q   <= '0;
        end else if (capture) begin
            // Lane k sits at the top-down position 1599-64k of the state bus
            for (int k = 0; k < DIGEST_WORDS; k++) begin
                lanes_q[k] <= state_in[1599-64*k -: 64];
            end
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // Word select by explicit compare keeps the 5-bit count independent of buffer depth
    always_comb begin
        cur_word = '0;
        for (int k = 0; k < DIGEST_WORDS; k++) begin
            if (cnt_q == 5'(k)) cur_word = lanes_q[k];
        end
    end

    // FSM outputs; out is forced to zero whenever no word is being offered
    always_comb begin
        state_ready = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        out         = '0;
        case (fsm_q)
            IDLE: state_ready = 1'b1;
            SEND: begin
                out_valid   = 1'b1;
                out_last    = at_last;
                busy        = 1'b1;
                out         = cur_word;
                state_ready = out_ready && at_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Directed bench for the squeeze serializer with expected-word scoreboards.
// Three instances: 8-word digest (main), 1-word and 25-word (length extremes).
// Stimulus pushes expected words; per-instance monitors pop on every handshake.
module tb_keccak_squeeze_serializer;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1599:0] st8 = '0, st1 = '0, st25 = '0;
    logic sv8 = 1'b0, sv1 = 1'b0, sv25 = 1'b0;
    logic or8 = 1'b0, or1 = 1'b0, or25 = 1'b0;
    logic sr8, sr1, sr25;
    logic [63:0] o8, o1, o25;
    logic ov8, ov1, ov25, ol8, ol1, ol25, b8, b1, b25;

    keccak_squeeze_serializer #(.DIGEST_WORDS(8)) dut8 (
        .clk(clk), .reset(reset), .state_in(st8), .state_valid(sv8), .state_ready(sr8),
        .out(o8), .out_valid(ov8), .out_ready(or8), .out_last(ol8), .busy(b8));
    keccak_squeeze_serializer #(.DIGEST_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .state_in(st1), .state_valid(sv1), .state_ready(sr1),
        .out(o1), .out_valid(ov1), .out_ready(or1), .out_last(ol1), .busy(b1));
    keccak_squeeze_serializer #(.DIGEST_WORDS(25)) dut25 (
        .clk(clk), .reset(reset), .state_in(st25), .state_valid(sv25), .state_ready(sr25),
        .out(o25), .out_valid(ov25), .out_ready(or25), .out_last(ol25), .busy(b25));

    int vectors = 0;
    int miscompares = 0;
    exp_t q8[$], q1[$], q25[$];
    exp_t e8, e1, e25;
    logic [64:0] hold8;
    logic        hold8_v = 1'b0;

    task automatic cmp(input string nm, input logic [64:0] act, input logic [64:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [1599:0] make_state(input logic [7:0] base);
        logic [1599:0] s;
        s = '0;
        for (int k = 0; k < 25; k++) s[1599-64*k -: 64] = 64'(base + 8'(k));
        return s;
    endfunction

    task automatic push8(input logic [7:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = 64'(base + 8'(i));
            e.l = (i == 7);
            q8.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: sample mid-cycle, a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        if (hold8_v && ov8) cmp("dut8_stall_stable", {o8, ol8}, hold8);
        if (!reset && ov8 && or8) begin
            if (q8.size() == 0) cmp("dut8_unexpected_word", {o8, ol8}, 65'h0);
            else begin
                e8 = q8.pop_front();
                cmp("dut8_word", {1'b0, o8}, {1'b0, e8.d});
                cmp("dut8_last", {64'h0, ol8}, {64'h0, e8.l});
            end
        end
        hold8_v = !reset && ov8 && !or8;
        hold8   = {o8, ol8};
    end

    always @(negedge clk) begin
        if (!reset && ov1 && or1) begin
            if (q1.size() == 0) cmp("dut1_unexpected_word", {o1, ol1}, 65'h0);
            else begin
                e1 = q1.pop_front();
                cmp("dut1_word_last", {o1, ol1}, {e1.d, e1.l});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov25 && or25) begin
            if (q25.size() == 0) cmp("dut25_unexpected_word", {o25, ol25}, 65'h0);
            else begin
                e25 = q25.pop_front();
                cmp("dut25_word_last", {o25, ol25}, {e25.d, e25.l});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic acc;
        exp_t e;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset_out", {1'b0, o8}, 65'h0);
        cmp("reset_flags", {61'h0, ov8, ol8, b8, sr8}, 65'h1);
        tick();
        reset = 1'b0;
        tick();

        // 1: full-rate stream of lanes 0..7
        st8 = make_state(8'h00); sv8 = 1'b1; or8 = 1'b1;
        push8(8'h00, 8);
        tick();
        sv8 = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        cmp("t1_idle_flags", {61'h0, ov8, ol8, b8, sr8}, 65'h1);
        cmp("t1_queue_empty", 65'(q8.size()), 65'h0);
        tick();

        // 2: stalling consumer, pattern 1,0,0 repeating
        st8 = make_state(8'h00); sv8 = 1'b1; or8 = 1'b0;
        push8(8'h00, 8);
        tick();
        sv8 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            or8 = (i % 3 == 0);
            tick();
        end
        or8 = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        cmp("t2_idle_busy", {64'h0, b8}, 65'h0);
        cmp("t2_queue_empty", 65'(q8.size()), 65'h0);
        tick();

        // 3: back-to-back states, valid held through the first stream
        st8 = make_state(8'h10); sv8 = 1'b1; or8 = 1'b1;
        push8(8'h10, 8);
        tick();
        st8 = make_state(8'h20);
        push8(8'h20, 8);
        pulses = 0;
        acc = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            cmp("t3_no_bubble", {64'h0, ov8}, 65'h1);
            cmp("t3_ready_only_on_last", {64'h0, sr8}, {64'h0, ol8});
            if (sr8) pulses++;
            acc = sr8 && sv8;
            tick();
            if (acc) sv8 = 1'b0;
        end
        cmp("t3_ready_pulses", 65'(pulses), 65'd2);
        @(negedge clk);
        cmp("t3_idle_busy", {64'h0, b8}, 65'h0);
        cmp("t3_queue_empty", 65'(q8.size()), 65'h0);
        tick();

        // 4: reset after four words have been handed off
        st8 = make_state(8'h30); sv8 = 1'b1; or8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.d = 64'(8'h30 + 8'(i));
            e.l = 1'b0;
            q8.push_back(e);
        end
        tick();
        sv8 = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        cmp("t4_reset_out", {1'b0, o8}, 65'h0);
        cmp("t4_reset_valid_busy", {63'h0, ov8, b8}, 65'h0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        cmp("t4_after_ready_busy", {63'h0, sr8, b8}, 65'h2);
        cmp("t4_queue_empty", 65'(q8.size()), 65'h0);
        tick();

        // 5: digest-length extremes with an all-ones state
        st1 = {1600{1'b1}}; st25 = {1600{1'b1}};
        sv1 = 1'b1; sv25 = 1'b1; or1 = 1'b1; or25 = 1'b1;
        e.d = 64'hFFFF_FFFF_FFFF_FFFF;
        e.l = 1'b1;
        q1.push_back(e);
        for (int i = 0; i < 25; i++) begin
            e.l = (i == 24);
            q25.push_back(e);
        end
        tick();
        sv1 = 1'b0; sv25 = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        cmp("t5_q1_empty", 65'(q1.size()), 65'h0);
        cmp("t5_q25_empty", 65'(q25.size()), 65'h0);
        cmp("t5_idle_busy", {63'h0, b1, b25}, 65'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
